reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; NREGS = 2**ADDR_W; legal range 2..6.
REQ-003 SHALL have parameter SP_INIT, default 32'h1001_03FC, initial value of register 2 (stack pointer), truncated or zero-extended to DATA_W.
REQ-004 SHALL have parameter GP_INIT, default 32'h1001_0000, initial value of register 3 (global pointer), truncated or zero-extended to DATA_W.
REQ-005 SHALL have port iCLK, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port iRST, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port iRegWrite, input, 1, write enable.
REQ-008 SHALL have port iWriteReg, input, ADDR_W, write address.
REQ-009 SHALL have port iWriteData, input, DATA_W, write data.
REQ-010 SHALL have ports iReadReg1 and iReadReg2, input, ADDR_W each, read addresses.
REQ-011 SHALL have port iRegDispSelect, input, ADDR_W, display/debug read address.
REQ-012 SHALL have ports oReadData1 and oReadData2, output, DATA_W each, read data.
REQ-013 SHALL have port oRegDisp, output, DATA_W, display read data.
REQ-014 SHALL have port iClearReq, input, 1, single-cycle request to start a clear sweep.
REQ-015 SHALL have port oClearBusy, output, 1, high while a sweep is running.
REQ-016 SHALL have port oClearDone, output, 1, one-cycle pulse when a sweep completes.

Function
REQ-017 Read ports SHALL be combinational: zero-cycle latency from address to data.
REQ-018 Register 0 SHALL read as zero at all times; writes to it are ignored.
REQ-019 A write with iRegWrite=1 and iWriteReg!=0 SHALL update the register at the next rising edge of iCLK, provided the FSM is in IDLE.
REQ-020 The "init value" of register r SHALL be SP_INIT for r=2, GP_INIT for r=3, and zero otherwise.
REQ-021 The FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-022 IDLE -> SWEEP on iClearReq=1; the sweep pointer loads 1.
REQ-023 In SWEEP, each cycle SHALL write the init value to register[ptr] and then increment ptr.
REQ-024 SWEEP -> DONE in the cycle that writes register NREGS-1; the sweep therefore lasts NREGS-1 cycles.
REQ-025 DONE -> IDLE unconditionally after one cycle; oClearDone=1 only in DONE.
REQ-026 oClearBusy SHALL be 1 in SWEEP and DONE and 0 in IDLE.
REQ-027 External writes SHALL be dropped while oClearBusy=1; they are not queued.
REQ-028 iClearReq SHALL be ignored while oClearBusy=1.
REQ-029 Reads during a sweep SHALL return current contents: already-swept registers return their init value, unswept registers return their old value.
REQ-030 If iClearReq=1 and iRegWrite=1 in the same IDLE cycle, the write SHALL be performed and the sweep SHALL start on that same edge; the sweep later overwrites the written register.

Reset
REQ-031 When iRST=1 at a clock edge, every register SHALL load its init value in that single cycle.
REQ-032 Reset SHALL force the FSM to IDLE and ptr to 0, giving oClearBusy=0 and oClearDone=0.
REQ-033 Reset SHALL take priority over writes and the sweep; a reset during SWEEP aborts the sweep and produces no oClearDone pulse.

Configuration
REQ-034 With REGFILE_BYPASS_EN defined, a read port whose address equals a non-zero iWriteReg SHALL return iWriteData combinationally when iRegWrite=1 and the FSM is in IDLE; this applies to all three read ports.
REQ-035 Without REGFILE_BYPASS_EN, read ports SHALL return the stored value only; a same-cycle write becomes visible after the edge.

Verification
REQ-036 Reset check: pulse iRST for 1 cycle -> x2 reads 1001_03FC, x3 reads 1001_0000, x0 and x31 read 0, oClearBusy=0.
REQ-037 Write/read and x0 check: write x5=DEADBEEF, then x0=12345678 -> oReadData1(x5)=DEADBEEF next cycle; x0 reads 0.
REQ-038 Sweep check: fill x1..x31 with FFFFFFFF, pulse iClearReq -> oClearBusy high for 32 cycles (31 SWEEP + 1 DONE), oClearDone pulses once, x2/x3 hold their init values, all other registers read 0.
REQ-039 Sweep collision check: during SWEEP, write x20=AAAA5555 and re-pulse iClearReq -> write is dropped, x20=0 after the sweep, exactly one oClearDone pulse.
REQ-040 Reset mid-sweep: assert iRST at sweep cycle 10 -> next cycle IDLE, all registers at init, no oClearDone pulse.
REQ-041 Bypass check: write x7=CAFEF00D with iReadReg2=7 in the same cycle -> oReadData2=CAFEF00D in that cycle with REGFILE_BYPASS_EN defined; without it, the old value in that cycle and CAFEF00D after the edge.

Source files
------------

// File: rtl/reg_file_param.sv
// Parameterised register file with three combinational read ports and a clear-sweep FSM.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_param #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter logic [31:0] SP_INIT = 32'h1001_03FC,
    parameter logic [31:0] GP_INIT = 32'h1001_0000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iRegWrite,
    input  logic [ADDR_W-1:0] iWriteReg,
    input  logic [DATA_W-1:0] iWriteData,
    input  logic [ADDR_W-1:0] iReadReg1,
    input  logic [ADDR_W-1:0] iReadReg2,
    input  logic [ADDR_W-1:0] iRegDispSelect,
    output logic [DATA_W-1:0] oReadData1,
    output logic [DATA_W-1:0] oReadData2,
    output logic [DATA_W-1:0] oRegDisp,
    input  logic              iClearReq,
    output logic              oClearBusy,
    output logic              oClearDone
);

    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] regs [NREGS];
    logic              wrEn;

    // Register 2 is the stack pointer and register 3 the global pointer.
    function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] r);
        if (r == ADDR_W'(2)) return DATA_W'(SP_INIT);
        if (r == ADDR_W'(3)) return DATA_W'(GP_INIT);
        return '0;
    endfunction

    assign wrEn = iRegWrite && (state == IDLE) && (iWriteReg != '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && iClearReq)
                ptr <= ADDR_W'(1);
            else if (state == SWEEP)
                ptr <= ptr + ADDR_W'(1);
        end
    end

    always_comb begin
        nextState  = state;
        oClearBusy = 1'b0;
        oClearDone = 1'b0;
        case (state)
            IDLE: begin
                if (iClearReq) nextState = SWEEP;
            end
            SWEEP: begin
                oClearBusy = 1'b1;
                if (ptr == ADDR_W'(NREGS - 1)) nextState = DONE;
            end
            DONE: begin
                oClearBusy = 1'b1;
                oClearDone = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // A write and a sweep request in the same idle cycle both take effect; the sweep overwrites later.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= initVal(ADDR_W'(i));
        end else if (wrEn) begin
            regs[iWriteReg] <= iWriteData;
        end else if (state == SWEEP) begin
            regs[ptr] <= initVal(ptr);
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        oReadData1 = (iReadReg1 == '0) ? '0 : regs[iReadReg1];
        oReadData2 = (iReadReg2 == '0) ? '0 : regs[iReadReg2];
        oRegDisp   = (iRegDispSelect == '0) ? '0 : regs[iRegDispSelect];
        if (wrEn && iReadReg1 == iWriteReg)      oReadData1 = iWriteData;
        if (wrEn && iReadReg2 == iWriteReg)      oReadData2 = iWriteData;
        if (wrEn && iRegDispSelect == iWriteReg) oRegDisp   = iWriteData;
    end
`else
    always_comb begin
        oReadData1 = (iReadReg1 == '0) ? '0 : regs[iReadReg1];
        oReadData2 = (iReadReg2 == '0) ? '0 : regs[iReadReg2];
        oRegDisp   = (iRegDispSelect == '0) ? '0 : regs[iRegDispSelect];
    end
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Directed scoreboard bench for reg_file_param (default 32x32 configuration).
module tb_reg_file_param;

    logic        iCLK = 1'b0;
    logic        iRST, iRegWrite, iClearReq;
    logic [4:0]  iWriteReg, iReadReg1, iReadReg2, iRegDispSelect;
    logic [31:0] iWriteData;
    logic [31:0] oReadData1, oReadData2, oRegDisp;
    logic        oClearBusy, oClearDone;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expQ[$];
    logic [31:0] mdl [32];
    int          busyCnt, doneCnt, guard;

    reg_file_param dut (
        .iCLK(iCLK), .iRST(iRST), .iRegWrite(iRegWrite), .iWriteReg(iWriteReg),
        .iWriteData(iWriteData), .iReadReg1(iReadReg1), .iReadReg2(iReadReg2),
        .iRegDispSelect(iRegDispSelect), .oReadData1(oReadData1), .oReadData2(oReadData2),
        .oRegDisp(oRegDisp), .iClearReq(iClearReq), .oClearBusy(oClearBusy),
        .oClearDone(oClearDone)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] initv(input int r);
        if (r == 2) return 32'h1001_03FC;
        if (r == 3) return 32'h1001_0000;
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        expQ.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic rdChk(input string tag, input int a, input logic [31:0] e);
        iReadReg1 = 5'(a); iReadReg2 = 5'(a); iRegDispSelect = 5'(a);
        #1;
        push(e); check({tag, ".rd1"}, oReadData1);
        push(e); check({tag, ".rd2"}, oReadData2);
        push(e); check({tag, ".disp"}, oRegDisp);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        iRegWrite = 1'b1; iWriteReg = 5'(a); iWriteData = d;
        tick();
        iRegWrite = 1'b0;
        if (a != 0) mdl[a] = d;
    endtask

    task automatic fillAll();
        for (int r = 1; r < 32; r++) wr(r, 32'hFFFF_FFFF);
    endtask

    task automatic resetModel();
        for (int r = 0; r < 32; r++) mdl[r] = initv(r);
    endtask

    initial begin
        iRST = 1'b1; iRegWrite = 1'b0; iClearReq = 1'b0; iWriteReg = '0;
        iWriteData = '0; iReadReg1 = '0; iReadReg2 = '0; iRegDispSelect = '0;
        tick(); tick();
        iRST = 1'b0;
        resetModel();

        // reset state
        rdChk("rst.x0", 0, 32'h0);
        rdChk("rst.x2", 2, 32'h1001_03FC);
        rdChk("rst.x3", 3, 32'h1001_0000);
        rdChk("rst.x31", 31, 32'h0);
        push(32'h0); check("rst.busy", {31'b0, oClearBusy});
        push(32'h0); check("rst.done", {31'b0, oClearDone});

        // plain write, then write to x0 which must be ignored even in the write cycle
        wr(5, 32'hDEAD_BEEF);
        iReadReg1 = 5'd0; iRegWrite = 1'b1; iWriteReg = 5'd0; iWriteData = 32'h1234_5678;
        #1;
        push(32'h0); check("x0.wrcycle", oReadData1);
        tick();
        iRegWrite = 1'b0;
        rdChk("wr.x5", 5, 32'hDEAD_BEEF);
        rdChk("wr.x0", 0, 32'h0);

        // same-cycle read of a register being written
        iReadReg2 = 5'd7; iRegDispSelect = 5'd7;
        iRegWrite = 1'b1; iWriteReg = 5'd7; iWriteData = 32'hCAFE_F00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        push(32'hCAFE_F00D); check("byp.rd2", oReadData2);
        push(32'hCAFE_F00D); check("byp.disp", oRegDisp);
`else
        push(mdl[7]); check("byp.rd2", oReadData2);
        push(mdl[7]); check("byp.disp", oRegDisp);
`endif
        tick();
        iRegWrite = 1'b0;
        mdl[7] = 32'hCAFE_F00D;
        rdChk("byp.after", 7, 32'hCAFE_F00D);

        // full sweep
        fillAll();
        iClearReq = 1'b1;
        tick();
        iClearReq = 1'b0;
        busyCnt = 0; doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (oClearBusy) busyCnt++;
            if (oClearDone) doneCnt++;
            if (c == 31) begin
                push(32'h1); check("sweep.doneAt31", {31'b0, oClearDone});
            end
            tick();
        end
        push(32'd32); check("sweep.busyCycles", 32'(busyCnt));
        push(32'd1);  check("sweep.donePulses", 32'(doneCnt));
        resetModel();
        for (int r = 0; r < 32; r++) rdChk("sweep.reg", r, mdl[r]);

        // collision: write and re-request during the sweep are dropped
        fillAll();
        iReadReg1 = 5'd5; iReadReg2 = 5'd6; iRegDispSelect = 5'd20;
        iClearReq = 1'b1;
        tick();
        iClearReq = 1'b0;
        busyCnt = 0; doneCnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (oClearBusy) busyCnt++;
            if (oClearDone) doneCnt++;
            if (c == 3) begin
                iRegWrite = 1'b1; iWriteReg = 5'd20; iWriteData = 32'hAAAA_5555; iClearReq = 1'b1;
            end
            if (c == 4) begin
                iRegWrite = 1'b0; iClearReq = 1'b0;
            end
            if (c == 5) begin
                #1;
                push(32'h0);         check("coll.swept5", oReadData1);
                push(32'hFFFF_FFFF); check("coll.unswept6", oReadData2);
            end
            if (c == 10) begin
                push(32'hFFFF_FFFF); check("coll.x20held", oRegDisp);
            end
            tick();
        end
        push(32'd32); check("coll.busyCycles", 32'(busyCnt));
        push(32'd1);  check("coll.donePulses", 32'(doneCnt));
        resetModel();
        rdChk("coll.x20", 20, 32'h0);

        // reset in the middle of a sweep
        fillAll();
        iClearReq = 1'b1;
        tick();
        iClearReq = 1'b0;
        doneCnt = 0;
        for (int c = 0; c < 9; c++) begin
            if (oClearDone) doneCnt++;
            tick();
        end
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        push(32'h0); check("rstmid.busy", {31'b0, oClearBusy});
        push(32'h0); check("rstmid.done", {31'b0, oClearDone});
        for (int c = 0; c < 40; c++) begin
            if (oClearDone) doneCnt++;
            tick();
        end
        push(32'h0); check("rstmid.donePulses", 32'(doneCnt));
        resetModel();
        for (int r = 0; r < 32; r++) rdChk("rstmid.reg", r, mdl[r]);

        // write and sweep request in the same idle cycle
        iRegWrite = 1'b1; iWriteReg = 5'd4; iWriteData = 32'h1111_2222; iClearReq = 1'b1;
        tick();
        iRegWrite = 1'b0; iClearReq = 1'b0;
        iReadReg1 = 5'd4;
        #1;
        push(32'h1111_2222); check("wrclr.written", oReadData1);
        push(32'h1);         check("wrclr.busy", {31'b0, oClearBusy});
        guard = 0;
        while (oClearBusy && guard < 60) begin
            tick();
            guard++;
        end
        push(32'h0); check("wrclr.idleInTime", {31'b0, oClearBusy});
        rdChk("wrclr.x4", 4, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
